// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetch PC, one-outstanding imem reads, prefetch buffer and IF/ID register.
// Define ALIGN_CHECK_EN to trap misaligned redirect targets (fetch_err + HALT); otherwise targets are word-aligned.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jmp_sig,
  input  logic [31:0] jmp_addr,
  output logic [31:0] ir_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_DROP = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [31:0]      buf_ir_q [FIFO_DEPTH];
  logic [31:0]      buf_ir_d [FIFO_DEPTH];
  logic [31:0]      buf_pc_q [FIFO_DEPTH];
  logic [31:0]      buf_pc_d [FIFO_DEPTH];

  logic xfer_c;
  logic wait_c;
  logic redirect_c;
  logic push_c;
  logic pop_c;
  logic misalign_c;
  logic err_c;
  logic halt_next_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign xfer_c     = req_q & imem_ready;
  assign wait_c     = req_q & ~imem_ready;
  assign redirect_c = valid_q & jmp_sig & ~stall;
  // Only responses to requests issued in RUN are kept; a redirect discards a same-edge response.
  assign push_c     = xfer_c & (state_q == ST_RUN) & ~redirect_c;
  assign pop_c      = ~stall & (count_q != '0) & ~redirect_c;
  assign halt_next_c = err_c | (redirect_c & misalign_c);

`ifdef ALIGN_CHECK_EN
  logic err_q, err_d;

  assign misalign_c = |jmp_addr[1:0];
  assign err_d      = err_q | (redirect_c & misalign_c);
  assign err_c      = err_q;
  assign fetch_err  = err_q;

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  logic unused_jmp_lo;

  assign misalign_c    = 1'b0;
  assign err_c         = 1'b0;
  assign fetch_err     = 1'b0;
  assign unused_jmp_lo = ^jmp_addr[1:0];
`endif

  // Next-state: buffer push/pop, IF/ID update, redirect and request issue.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    buf_ir_d   = buf_ir_q;
    buf_pc_d   = buf_pc_q;

    if (push_c) begin
      buf_ir_d[wr_ptr_q] = imem_rdata;
      buf_pc_d[wr_ptr_q] = addr_q + 32'd4;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
      fetch_pc_d         = fetch_pc_q + 32'd4;
    end

    if (pop_c) begin
      ir_d     = buf_ir_q[rd_ptr_q];
      pc_d     = buf_pc_q[rd_ptr_q];
      valid_d  = 1'b1;
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else if (!stall) begin
      ir_d    = '0;
      valid_d = 1'b0;
    end

    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    if (redirect_c) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      ir_d       = '0;
      valid_d    = 1'b0;
      fetch_pc_d = {jmp_addr[31:2], 2'b00};
      // A request still waiting for ready must complete before the new target can issue.
      if (wait_c) begin
        state_d = ST_DROP;
      end else begin
        state_d = halt_next_c ? ST_HALT : ST_RUN;
      end
    end else if ((state_q == ST_DROP) && xfer_c) begin
      state_d = halt_next_c ? ST_HALT : ST_RUN;
    end

    if (state_q == ST_HALT) begin
      ir_d    = '0;
      valid_d = 1'b0;
    end

    // A raised request holds address until accepted; otherwise re-evaluate issue.
    if (!wait_c) begin
      req_d  = (state_d == ST_RUN) && (count_d < CNT_FULL);
      addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ir_q       <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  // Buffer storage is qualified by count/pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    buf_ir_q <= buf_ir_d;
    buf_pc_q <= buf_pc_d;
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir_out    = ir_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: transfers push expected IF/ID entries, each clock compares the IF/ID register.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jmp_sig;
  logic [31:0] jmp_addr;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];
  logic [31:0] exp_pc  = RST_PC;
  logic [31:0] exp_ir  = '0;
  logic [31:0] exp_pco = '0;
  logic        exp_v   = 1'b0;
  logic        drop_pend = 1'b0;
  logic        halted  = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  if_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .jmp_sig(jmp_sig), .jmp_addr(jmp_addr),
    .ir_out(ir_out), .pc_out(pc_out), .valid_out(valid_out), .fetch_err(fetch_err)
  );

  // One clock: update the reference model from the inputs, advance, compare IF/ID.
  task automatic tick();
    logic xf;
    logic rd;
    logic [63:0] e;
    xf = imem_req & imem_ready;
    rd = rst_n & jmp_sig & exp_v & ~stall;
    if (rst_n && imem_req && !drop_pend && !halted) begin
      total++;
      if (imem_addr !== exp_pc) begin
        bad++;
        $display("FAIL fetch_addr got=%h exp=%h", imem_addr, exp_pc);
      end
    end
    if (!rst_n) begin
      sb.delete();
      exp_v = 1'b0; exp_ir = '0; exp_pco = '0; exp_pc = RST_PC;
      drop_pend = 1'b0; halted = 1'b0;
    end else if (rd) begin
      sb.delete();
      exp_v = 1'b0; exp_ir = '0;
      if (xf) drop_pend = 1'b0;
      else if (imem_req) drop_pend = 1'b1;
      exp_pc = {jmp_addr[31:2], 2'b00};
`ifdef ALIGN_CHECK_EN
      if (jmp_addr[1:0] != 2'b00) halted = 1'b1;
`endif
    end else begin
      if (!stall) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          exp_ir = e[63:32]; exp_pco = e[31:0]; exp_v = 1'b1;
        end else begin
          exp_ir = '0; exp_v = 1'b0;
        end
      end
      if (xf) begin
        if (drop_pend) drop_pend = 1'b0;
        else if (!halted) begin
          sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    total++;
    if ({valid_out, ir_out, pc_out} !== {exp_v, exp_ir, exp_pco}) begin
      bad++;
      $display("FAIL if_id got v=%b ir=%h pc=%h exp v=%b ir=%h pc=%h",
               valid_out, ir_out, pc_out, exp_v, exp_ir, exp_pco);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; jmp_sig = 1'b0; jmp_addr = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    total++;
    if (fetch_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", fetch_err); end
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      bad++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    tick(); tick(); tick();
    total++;
    if (valid_out !== 1'b1 || pc_out !== RST_PC + 32'd4 || ir_out !== mem_word(RST_PC)) begin
      bad++; $display("FAIL first_valid got v=%b pc=%h ir=%h exp v=1 pc=%h ir=%h",
                      valid_out, pc_out, ir_out, RST_PC + 32'd4, mem_word(RST_PC));
    end
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_ready_low();
    logic seen_bubble;
    seen_bubble = 1'b0;
    do_reset();
    tick(); tick(); tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin
        bad++; $display("FAIL wait_hold got req=%b addr=%h exp req=1 addr=00400008", imem_req, imem_addr);
      end
      tick();
      if (valid_out === 1'b0) seen_bubble = 1'b1;
    end
    total++;
    if (seen_bubble !== 1'b1) begin bad++; $display("FAIL wait_bubble got=%b exp=1", seen_bubble); end
    imem_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_stall();
    logic [31:0] held;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    held = exp_ir;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_full_req got=%b exp=0", imem_req); end
    total++;
    if (ir_out !== held) begin bad++; $display("FAIL stall_hold got=%h exp=%h", ir_out, held); end
    stall = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_redirect();
    logic found;
    logic seen_wrap;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    jmp_sig = 1'b1; jmp_addr = 32'h0040_0100;
    tick();
    jmp_sig = 1'b0;
    total++;
    if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin
      bad++; $display("FAIL redir_next got v=%b req=%b addr=%h exp v=0 req=1 addr=00400100",
                      valid_out, imem_req, imem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!found && valid_out === 1'b1) begin
        found = 1'b1;
        total++;
        if (pc_out !== 32'h0040_0104) begin bad++; $display("FAIL redir_pc got=%h exp=00400104", pc_out); end
      end
    end
    total++;
    if (found !== 1'b1) begin bad++; $display("FAIL redir_timeout got=%b exp=1", found); end
    jmp_sig = 1'b1; jmp_addr = 32'hFFFF_FFF8;
    tick();
    jmp_sig = 1'b0;
    seen_wrap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid_out === 1'b1 && pc_out === 32'h0) seen_wrap = 1'b1;
    end
    total++;
    if (seen_wrap !== 1'b1) begin bad++; $display("FAIL pc_wrap got=%b exp=1", seen_wrap); end
  endtask

  task automatic test_redirect_drop();
    logic found;
    do_reset();
    tick(); tick(); tick();
    imem_ready = 1'b0;
    tick();
    jmp_sig = 1'b1; jmp_addr = 32'h0040_0100;
    tick();
    jmp_sig = 1'b0;
    total++;
    if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin
      bad++; $display("FAIL drop_hold got v=%b req=%b addr=%h exp v=0 req=1 addr=00400008",
                      valid_out, imem_req, imem_addr);
    end
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0008) begin
      bad++; $display("FAIL drop_wait got req=%b addr=%h exp req=1 addr=00400008", imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100) begin
      bad++; $display("FAIL drop_retarget got req=%b addr=%h exp req=1 addr=00400100", imem_req, imem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!found && valid_out === 1'b1) begin
        found = 1'b1;
        total++;
        if (pc_out !== 32'h0040_0104 || ir_out !== mem_word(32'h0040_0100)) begin
          bad++; $display("FAIL drop_first got pc=%h ir=%h exp pc=00400104 ir=%h",
                          pc_out, ir_out, mem_word(32'h0040_0100));
        end
      end
    end
    total++;
    if (found !== 1'b1) begin bad++; $display("FAIL drop_timeout got=%b exp=1", found); end
  endtask

  task automatic test_misalign();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    jmp_sig = 1'b1; jmp_addr = 32'h0040_0102;
    tick();
    jmp_sig = 1'b0;
`ifdef ALIGN_CHECK_EN
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL halt got err=%b req=%b v=%b exp err=1 req=0 v=0", fetch_err, imem_req, valid_out);
    end
`else
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL align_force got req=%b addr=%h err=%b exp req=1 addr=00400100 err=0",
                      imem_req, imem_addr, fetch_err);
    end
    for (int i = 0; i < 6; i++) tick();
`endif
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0; jmp_sig = 1'b0; jmp_addr = '0;
    test_reset();
    test_stream();
    test_ready_low();
    test_stall();
    test_redirect();
    test_redirect_drop();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
